// File: rtl/cg_memory_beh_if.sv
// Request/response bundle between a requester and the cg_memory_beh backing store.
// The master modport is the requester side and the slave modport is the memory side.
interface cg_memory_beh_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  wen;
    logic                  wdata_valid;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wready;
    logic                  raddr_valid;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rdata_ready;
    logic                  raddr_ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;

    modport master (
        output wen,
        output wdata_valid,
        output waddr,
        output wdata,
        input  wready,
        output raddr_valid,
        output raddr,
        output rdata_ready,
        input  raddr_ready,
        input  rdata,
        input  rdata_valid
    );

    modport slave (
        input  wen,
        input  wdata_valid,
        input  waddr,
        input  wdata,
        output wready,
        input  raddr_valid,
        input  raddr,
        input  rdata_ready,
        output raddr_ready,
        output rdata,
        output rdata_valid
    );
endinterface

// File: rtl/cg_memory_beh.sv
// Zero-wait-state 1W/1R word memory with a registered read port. Same-index read/write is
// read-first by default; defining CG_MEM_BYPASS_EN forwards the new write data instead.
module cg_memory_beh #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_NUM   = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    cg_memory_beh_if.slave        bus_io
);
    localparam int unsigned IdxW = $clog2(WORD_NUM);

    logic [DATA_WIDTH-1:0] mem_q [WORD_NUM] = '{default: '0};
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic                  rvalid_d, rvalid_q;
    logic [IdxW-1:0]       widx, ridx;
    logic                  wr_fire, rd_fire;

    // Upper address bits are dropped so addresses alias modulo WORD_NUM.
    assign widx    = bus_io.waddr[IdxW-1:0];
    assign ridx    = bus_io.raddr[IdxW-1:0];
    assign wr_fire = bus_io.wen & bus_io.wdata_valid;
    assign rd_fire = bus_io.raddr_valid & bus_io.rdata_ready;

    if (ADDR_WIDTH > IdxW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{bus_io.waddr[ADDR_WIDTH-1:IdxW],
                                  bus_io.raddr[ADDR_WIDTH-1:IdxW]};
    end

    // An X qualifier makes the if-condition false, so it behaves as no operation.
    always_ff @(posedge i_clk) begin
        if (i_rstn && wr_fire) begin
            mem_q[widx] <= bus_io.wdata;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_q[ridx];
`ifdef CG_MEM_BYPASS_EN
            if (wr_fire && (widx == ridx)) begin
                rdata_d = bus_io.wdata;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus_io.rdata       = rdata_q;
    assign bus_io.rdata_valid = rvalid_q;
    assign bus_io.wready      = i_rstn;
    assign bus_io.raddr_ready = i_rstn;
endmodule

// File: tb/tb_cg_memory_beh.sv
// Directed self-checking bench for cg_memory_beh; honours CG_MEM_BYPASS_EN for the
// same-index read/write expectation.
module tb_cg_memory_beh;
    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;

    cg_memory_beh_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    cg_memory_beh #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .WORD_NUM  (1024)
    ) u_dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_val);
        end
    endtask

    // Advance past the next rising edge; outputs are stable here and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.wen         = 1'b0;
        bus.wdata_valid = 1'b0;
        bus.waddr       = '0;
        bus.wdata       = '0;
        bus.raddr_valid = 1'b0;
        bus.raddr       = '0;
        bus.rdata_ready = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        bus.wen         = 1'b1;
        bus.wdata_valid = 1'b1;
        bus.waddr       = addr;
        bus.wdata       = data;
        step();
        idle_bus();
        step();
    endtask

    // One-cycle read; checks the response and that valid drops the cycle after.
    task automatic read_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_val);
        bus.raddr_valid = 1'b1;
        bus.rdata_ready = 1'b1;
        bus.raddr       = addr;
        step();
        idle_bus();
        check({tag, " rdata"}, bus.rdata, exp_val);
        check({tag, " valid"}, {31'd0, bus.rdata_valid}, 32'd1);
        step();
        check({tag, " valid drop"}, {31'd0, bus.rdata_valid}, 32'd0);
        check({tag, " rdata hold"}, bus.rdata, exp_val);
    endtask

    logic [31:0] same_exp;

    initial begin
`ifdef CG_MEM_BYPASS_EN
        same_exp = 32'h0000_0314;
`else
        same_exp = 32'hAAAA_AAAA;
`endif
        rstn = 1'b0;
        idle_bus();
        step();
        step();
        check("reset rdata", bus.rdata, 32'h0);
        check("reset rvalid", {31'd0, bus.rdata_valid}, 32'd0);
        check("reset wready", {31'd0, bus.wready}, 32'd0);
        check("reset raddr_ready", {31'd0, bus.raddr_ready}, 32'd0);
        rstn = 1'b1;
        step();
        check("wready", {31'd0, bus.wready}, 32'd1);
        check("raddr_ready", {31'd0, bus.raddr_ready}, 32'd1);

        read_check("zero init", 32'h0000_03FF, 32'h0);

        write_word(32'h0000_0514, 32'h0000_0114);
        write_word(32'h0000_0515, 32'h0000_0214);
        write_word(32'h0000_0516, 32'hAAAA_AAAA);
        read_check("read 514", 32'h0000_0514, 32'h0000_0114);

        // Same-index read and write in one cycle.
        bus.raddr_valid = 1'b1;
        bus.rdata_ready = 1'b1;
        bus.raddr       = 32'h0000_0516;
        bus.wen         = 1'b1;
        bus.wdata_valid = 1'b1;
        bus.waddr       = 32'h0000_0516;
        bus.wdata       = 32'h0000_0314;
        step();
        idle_bus();
        check("same idx rdata", bus.rdata, same_exp);
        check("same idx valid", {31'd0, bus.rdata_valid}, 32'd1);
        step();
        read_check("after same idx", 32'h0000_0516, 32'h0000_0314);

        // Different indices in one cycle.
        bus.raddr_valid = 1'b1;
        bus.rdata_ready = 1'b1;
        bus.raddr       = 32'h0000_0515;
        bus.wen         = 1'b1;
        bus.wdata_valid = 1'b1;
        bus.waddr       = 32'h0000_0517;
        bus.wdata       = 32'h1234_5678;
        step();
        idle_bus();
        check("diff idx rdata", bus.rdata, 32'h0000_0214);
        step();
        read_check("diff idx write", 32'h0000_0517, 32'h1234_5678);

        write_word(32'h0000_0114, 32'hDEAD_BEEF);
        read_check("alias 514", 32'h0000_0514, 32'hDEAD_BEEF);
        read_check("index 115", 32'h0000_0515, 32'h0000_0214);

        // Half-qualified writes must not store.
        bus.wen   = 1'b1;
        bus.waddr = 32'h0000_0516;
        bus.wdata = 32'h0000_0BAD;
        step();
        bus.wen         = 1'b0;
        bus.wdata_valid = 1'b1;
        step();
        idle_bus();
        read_check("no half write", 32'h0000_0516, 32'h0000_0314);

        bus.raddr_valid = 1'b1;
        bus.raddr       = 32'h0000_0514;
        step();
        check("no rdy read", {31'd0, bus.rdata_valid}, 32'd0);
        bus.raddr_valid = 1'b0;
        bus.rdata_ready = 1'b1;
        step();
        idle_bus();
        check("no valid read", {31'd0, bus.rdata_valid}, 32'd0);

        // Reset right after an accept, with requests held during reset.
        bus.raddr_valid = 1'b1;
        bus.rdata_ready = 1'b1;
        bus.raddr       = 32'h0000_0514;
        step();
        check("pre-reset rdata", bus.rdata, 32'hDEAD_BEEF);
        rstn            = 1'b0;
        bus.wen         = 1'b1;
        bus.wdata_valid = 1'b1;
        bus.waddr       = 32'h0000_0516;
        bus.wdata       = 32'h0000_0BAD;
        step();
        check("rst1 rdata", bus.rdata, 32'h0);
        check("rst1 rvalid", {31'd0, bus.rdata_valid}, 32'd0);
        step();
        check("rst2 rvalid", {31'd0, bus.rdata_valid}, 32'd0);
        check("rst2 wready", {31'd0, bus.wready}, 32'd0);
        check("rst2 raddr_ready", {31'd0, bus.raddr_ready}, 32'd0);
        idle_bus();
        rstn = 1'b1;
        step();
        read_check("post reset", 32'h0000_0516, 32'h0000_0314);

        // Streaming reads on consecutive cycles.
        write_word(32'h0000_0514, 32'h0000_0114);
        bus.raddr_valid = 1'b1;
        bus.rdata_ready = 1'b1;
        bus.raddr       = 32'h0000_0514;
        step();
        bus.raddr       = 32'h0000_0515;
        check("stream0", bus.rdata, 32'h0000_0114);
        check("stream0 valid", {31'd0, bus.rdata_valid}, 32'd1);
        step();
        bus.raddr       = 32'h0000_0516;
        check("stream1", bus.rdata, 32'h0000_0214);
        check("stream1 valid", {31'd0, bus.rdata_valid}, 32'd1);
        step();
        idle_bus();
        check("stream2", bus.rdata, 32'h0000_0314);
        check("stream2 valid", {31'd0, bus.rdata_valid}, 32'd1);
        step();
        check("stream end valid", {31'd0, bus.rdata_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
